// File: rtl/ps2_transmisor_if.sv
// Signal bundle between a PS/2 host transmitter and its user/line side:
// command handshake, sampled PS/2 lines and open-drain pull-down enables.
interface ps2_transmisor_if;
  logic [7:0] Dato_tx;
  logic       wr_ps2;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       err_tick;

  modport master (
    output Dato_tx, wr_ps2, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, err_tick
  );

  modport slave (
    input  Dato_tx, wr_ps2, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, err_tick
  );
endinterface

// File: rtl/ps2_transmisor.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data LSB first, odd parity, stop, ACK).
// Optional device-clock watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_transmisor #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst,
  ps2_transmisor_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RTS, START, DATA, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;

  localparam int            CW       = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INHIBIT_CYCLES - 1);

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Filtered level only moves once eight consecutive samples agree.
  function automatic logic filt_next(input logic [7:0] sr, input logic cur);
    logic r;
    if (sr == 8'hFF) begin
      r = 1'b1;
    end else if (sr == 8'h00) begin
      r = 1'b0;
    end else begin
      r = cur;
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [7:0]    csr_q, csr_d, dsr_q, dsr_d;
  logic          cfilt_q, cfilt_d, dfilt_q, dfilt_d;
  logic          fall_s;
  logic          c_oe_q, c_oe_d, d_oe_q, d_oe_d;
  logic          idle_q, idle_d, done_q, done_d, err_q, err_d;
  logic          wd_expired_s;

  // Line filters and device clock fall detection
  always_comb begin
    csr_d   = {bus.ps2c_in, csr_q[7:1]};
    dsr_d   = {bus.ps2d_in, dsr_q[7:1]};
    cfilt_d = filt_next(csr_d, cfilt_q);
    dfilt_d = filt_next(dsr_d, dfilt_q);
    fall_s  = cfilt_q & ~cfilt_d;
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          watched_s;

  assign watched_s    = (state_q != IDLE) && (state_q != RTS);
  assign wd_expired_s = watched_s && !fall_s && (wd_q == WD_LAST);

  // Watchdog restarts on every device clock edge and every state change
  always_comb begin
    wd_d = '0;
    if (!watched_s || fall_s || (state_d != state_q)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + TW'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // Watchdog compiled out: a stalled device simply leaves the FSM waiting.
  assign wd_expired_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next state and frame bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (wd_expired_s) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // idle_q is low during the tick cycle, so a request there is dropped
          if (bus.wr_ps2 && idle_q) begin
            data_d  = bus.Dato_tx;
            par_d   = odd_parity(bus.Dato_tx);
            cnt_d   = '0;
            idx_d   = 3'd0;
            state_d = RTS;
          end else begin
            state_d = IDLE;
          end
        end
        RTS: begin
          if (cnt_q == CNT_LAST) begin
            state_d = START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        START: begin
          if (fall_s) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (fall_s) begin
            if (idx_q == 3'd7) begin
              state_d = PARITY;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          if (fall_s) begin
            state_d = STOP;
          end else begin
            state_d = PARITY;
          end
        end
        STOP: begin
          if (fall_s) begin
            state_d = ACK;
          end else begin
            state_d = STOP;
          end
        end
        ACK: begin
          if (fall_s) begin
            if (dfilt_q == 1'b0) begin
              state_d = WAIT_IDLE;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end else begin
            state_d = ACK;
          end
        end
        WAIT_IDLE: begin
          if (cfilt_q && dfilt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    c_oe_d = (state_d == RTS);
    idle_d = (state_d == IDLE) && !done_d && !err_d;
    d_oe_d = 1'b0;
    case (state_d)
      RTS:     d_oe_d = (cnt_d == CNT_LAST);
      START:   d_oe_d = 1'b1;
      DATA:    d_oe_d = ~data_d[idx_d];
      PARITY:  d_oe_d = ~par_d;
      default: d_oe_d = 1'b0;
    endcase
  end

  // State, filter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      csr_q   <= 8'hFF;
      dsr_q   <= 8'hFF;
      cfilt_q <= 1'b1;
      dfilt_q <= 1'b1;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      csr_q   <= csr_d;
      dsr_q   <= dsr_d;
      cfilt_q <= cfilt_d;
      dfilt_q <= dfilt_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ps2c_oe      = c_oe_q;
  assign bus.ps2d_oe      = d_oe_q;
  assign bus.tx_idle      = idle_q;
  assign bus.tx_done_tick = done_q;
  assign bus.err_tick     = err_q;

endmodule

// File: tb/tb_ps2_transmisor.sv
// Bench for ps2_transmisor: a PS/2 device model clocks frames in and a reference
// built from the frame rules (start 0, data LSB first, odd parity, stop 1) checks them.
module tb_ps2_transmisor;
  localparam int INH  = 5000;
  localparam int TOUT = 3000;
  localparam int HALF = 20;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_fall_cyc = 0;
  int c_oe_cycles = 0, d_oe_in_rts = 0, done_cnt = 0, err_cnt = 0;

  always #5 clk = ~clk;

  ps2_transmisor_if bus ();
  assign bus.ps2c_in = ~bus.ps2c_oe & dev_clk;
  assign bus.ps2d_in = ~bus.ps2d_oe & dev_data;

  ps2_transmisor #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Output activity counters, sampled away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.ps2c_oe === 1'b1) c_oe_cycles <= c_oe_cycles + 1;
    if (bus.ps2c_oe === 1'b1 && bus.ps2d_oe === 1'b1) d_oe_in_rts <= d_oe_in_rts + 1;
    if (bus.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.err_tick === 1'b1) err_cnt <= err_cnt + 1;
  end

  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (ones % 2 == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic clear_mon();
    c_oe_cycles = 0;
    d_oe_in_rts = 0;
    done_cnt    = 0;
    err_cnt     = 0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    bus.Dato_tx = b;
    bus.wr_ps2  = 1'b1;
    @(negedge clk);
    bus.wr_ps2  = 1'b0;
    bus.Dato_tx = 8'($urandom);
  endtask

  // Device side: wait out the inhibit, then sample data before each falling edge.
  task automatic device_run(input int n_pulses, input bit do_ack, input int glitch_pulse,
                            input logic [7:0] late_byte, output logic [10:0] seen, output bit ok);
    int w1, w2;
    ok = 1'b1; seen = '1; w1 = 0; w2 = 0;
    while (bus.ps2c_oe !== 1'b1 && w1 < 10) begin @(negedge clk); w1++; end
    while (bus.ps2c_oe !== 1'b0 && w2 < INH + 20) begin @(negedge clk); w2++; end
    if (w1 >= 10 || w2 >= INH + 20) begin
      ok = 1'b0;
      return;
    end
    repeat (20) @(negedge clk);
    for (int k = 1; k <= n_pulses; k++) begin
      if (k <= 11) seen[k-1] = bus.ps2d_in;
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      if (k == 11 && do_ack) dev_data = 1'b0;
      if (k == 12) dev_data = 1'b1;
      dev_clk = 1'b1;
      if (k == glitch_pulse) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        bus.Dato_tx = late_byte;
        bus.wr_ps2  = 1'b1;
        @(negedge clk);
        bus.wr_ps2  = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.ps2c_oe, bus.ps2d_oe, bus.tx_idle, bus.tx_done_tick, bus.err_tick} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 00100",
               {bus.ps2c_oe, bus.ps2d_oe, bus.tx_idle, bus.tx_done_tick, bus.err_tick});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_ed();
    logic [10:0] seen;
    bit ok;
    clear_mon();
    start_tx(8'hED);
    n_checks++;
    if (bus.ps2c_oe !== 1'b1) begin n_fail++; $display("FAIL c_oe_after_wr: got %b want 1", bus.ps2c_oe); end
    device_run(12, 1'b1, 0, 8'h00, seen, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_inhibit_wait: got %b want 1", ok); end
    n_checks++;
    if (seen !== ref_frame(8'hED)) begin n_fail++; $display("FAIL ed_frame: got %b want %b", seen, ref_frame(8'hED)); end
    n_checks++;
    if (c_oe_cycles !== INH) begin n_fail++; $display("FAIL ed_inhibit_len: got %0d want %0d", c_oe_cycles, INH); end
    n_checks++;
    if (d_oe_in_rts !== 1) begin n_fail++; $display("FAIL ed_rts_data_low: got %0d want 1", d_oe_in_rts); end
    n_checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL ed_ticks: got done=%0d err=%0d want 1 0", done_cnt, err_cnt);
    end
    n_checks++;
    if (bus.tx_idle !== 1'b1) begin n_fail++; $display("FAIL ed_idle: got %b want 1", bus.tx_idle); end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [2] = '{8'h00, 8'h01};
    logic       exp_p [2] = '{1'b1, 1'b0};
    logic [10:0] seen;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      start_tx(bytes[i]);
      device_run(12, 1'b1, 0, 8'h00, seen, ok);
      repeat (5) @(negedge clk);
      n_checks++;
      if (seen[9] !== exp_p[i]) begin n_fail++; $display("FAIL parity_%0d: got %b want %b", i, seen[9], exp_p[i]); end
      n_checks++;
      if (seen !== ref_frame(bytes[i]) || done_cnt !== 1) begin
        n_fail++; $display("FAIL parity_frame_%0d: got %b done=%0d want %b done=1", i, seen, done_cnt, ref_frame(bytes[i]));
      end
    end
  endtask

  task automatic test_nack();
    logic [10:0] seen;
    logic [7:0] b;
    bit ok, got_err;
    int w;
    b = 8'($urandom);
    clear_mon();
    start_tx(b);
    device_run(11, 1'b0, 0, 8'h00, seen, ok);
    dev_clk = 1'b0;
    w = 0; got_err = 1'b0;
    while (!got_err && w < 40) begin
      @(negedge clk); w++;
      if (bus.err_tick === 1'b1) got_err = 1'b1;
    end
    // Request in the very cycle err_tick is high must be dropped
    bus.Dato_tx = 8'h12;
    bus.wr_ps2  = got_err;
    @(negedge clk);
    bus.wr_ps2  = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (got_err !== 1'b1 || seen !== ref_frame(b)) begin
      n_fail++; $display("FAIL nack_err_seen: got err=%b frame=%b want 1 %b", got_err, seen, ref_frame(b));
    end
    n_checks++;
    if (err_cnt !== 1 || done_cnt !== 0) begin
      n_fail++; $display("FAIL nack_ticks: got err=%0d done=%0d want 1 0", err_cnt, done_cnt);
    end
    n_checks++;
    if (bus.tx_idle !== 1'b1 || bus.ps2c_oe !== 1'b0 || c_oe_cycles !== INH) begin
      n_fail++; $display("FAIL nack_wr_ignored: got idle=%b c_oe=%b c_oe_cycles=%0d want 1 0 %0d",
                         bus.tx_idle, bus.ps2c_oe, c_oe_cycles, INH);
    end
  endtask

  task automatic test_midframe_reset();
    logic [10:0] seen;
    bit ok;
    clear_mon();
    start_tx(8'h00);
    device_run(4, 1'b0, 0, 8'h00, seen, ok);
    n_checks++;
    if (bus.ps2d_oe !== 1'b1) begin n_fail++; $display("FAIL mid_data_driven: got %b want 1", bus.ps2d_oe); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.ps2c_oe, bus.ps2d_oe, bus.tx_idle, bus.tx_done_tick, bus.err_tick} !== 5'b00100) begin
      n_fail++; $display("FAIL mid_reset_release: got %b want 00100",
                         {bus.ps2c_oe, bus.ps2d_oe, bus.tx_idle, bus.tx_done_tick, bus.err_tick});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (err_cnt !== 0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL mid_reset_ticks: got err=%0d done=%0d want 0 0", err_cnt, done_cnt);
    end
    clear_mon();
    start_tx(8'hF4);
    device_run(12, 1'b1, 0, 8'h00, seen, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (seen !== ref_frame(8'hF4) || done_cnt !== 1 || c_oe_cycles !== INH) begin
      n_fail++; $display("FAIL after_reset_f4: got %b done=%0d c_oe=%0d want %b 1 %0d",
                         seen, done_cnt, c_oe_cycles, ref_frame(8'hF4), INH);
    end
  endtask

  task automatic test_glitch_ignore();
    logic [10:0] seen;
    bit ok;
    clear_mon();
    start_tx(8'hED);
    device_run(12, 1'b1, 5, 8'h55, seen, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (seen !== ref_frame(8'hED)) begin n_fail++; $display("FAIL glitch_frame: got %b want %b", seen, ref_frame(8'hED)); end
    n_checks++;
    if (done_cnt !== 1 || err_cnt !== 0 || c_oe_cycles !== INH) begin
      n_fail++; $display("FAIL glitch_ticks: got done=%0d err=%0d c_oe=%0d want 1 0 %0d", done_cnt, err_cnt, c_oe_cycles, INH);
    end
  endtask

  task automatic test_random();
    logic [10:0] seen;
    logic [7:0] b;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      clear_mon();
      start_tx(b);
      device_run(12, 1'b1, 0, 8'h00, seen, ok);
      repeat (5) @(negedge clk);
      n_checks++;
      if (seen !== ref_frame(b) || done_cnt !== 1 || err_cnt !== 0) begin
        n_fail++; $display("FAIL random_%0d: got %b done=%0d err=%0d want %b 1 0", i, seen, done_cnt, err_cnt, ref_frame(b));
      end
    end
  endtask

  task automatic test_stall();
    logic [10:0] seen;
    bit ok;
    clear_mon();
    start_tx(8'($urandom));
    device_run(5, 1'b0, 0, 8'h00, seen, ok);
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int w, delay;
      w = 0;
      while (bus.err_tick !== 1'b1 && w < TOUT + 100) begin @(negedge clk); w++; end
      delay = cyc - last_fall_cyc;
      n_checks++;
      if (bus.err_tick !== 1'b1 || delay < TOUT || delay > TOUT + 20) begin
        n_fail++; $display("FAIL timeout_delay: got err=%b delay=%0d want 1 in [%0d,%0d]",
                           bus.err_tick, delay, TOUT, TOUT + 20);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.ps2c_oe, bus.ps2d_oe, bus.tx_idle} !== 3'b001) begin
        n_fail++; $display("FAIL timeout_release: got %b want 001", {bus.ps2c_oe, bus.ps2d_oe, bus.tx_idle});
      end
    end
`else
    repeat (TOUT) @(negedge clk);
    n_checks++;
    if (err_cnt !== 0 || bus.tx_idle !== 1'b0) begin
      n_fail++; $display("FAIL stall_waits: got err=%0d idle=%b want 0 0", err_cnt, bus.tx_idle);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL global_timeout: got no finish want finish before 150000 cycles");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bus.Dato_tx = 8'h00;
    bus.wr_ps2  = 1'b0;
    test_reset();
    test_basic_ed();
    test_parity();
    test_nack();
    test_midframe_reset();
    test_glitch_ignore();
    test_random();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
